// File: rtl/gru_pkg.sv
// Shared types and helpers for the GRU gate sequencer slice.
package gru_pkg;

   // Sequencer FSM states.
   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StUpdate,
      StDone
   } seq_state_t;

   // Row-index width for h rows; a single row still needs one bit.
   function automatic int unsigned row_w(input int unsigned h);
      return (h > 1) ? $clog2(h) : 1;
   endfunction

   // Signed saturation of a wide value to a dw-bit signed range; caller truncates.
   function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                       input int unsigned dw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/gru_gate_sequencer_if.sv
// Handshake between the sequencer and the time-multiplexed gate element plus
// the per-row z/h_prev operand muxes selected by row_idx.
interface gru_gate_sequencer_if
   import gru_pkg::*;
#(
   parameter int unsigned H          = 256,
   parameter int unsigned DATA_WIDTH = 16
);
   localparam int unsigned RowW = row_w(H);

   logic [RowW-1:0]              row_idx;
   logic                         elem_valid_in;
   logic                         elem_valid_out;
   logic signed [DATA_WIDTH-1:0] elem_result;
   logic signed [DATA_WIDTH-1:0] z_t_n;
   logic signed [DATA_WIDTH-1:0] h_prev_n;

   modport master (
      output row_idx, elem_valid_in,
      input  elem_valid_out, elem_result, z_t_n, h_prev_n
   );

   modport slave (
      input  row_idx, elem_valid_in,
      output elem_valid_out, elem_result, z_t_n, h_prev_n
   );
endinterface

// File: rtl/gru_hidden_update_alu.sv
// Combinational hidden-state blend: h_new = sat(n + ((z * (h_prev - n)) >>> FRAC_BITS)).
// Supports DATA_WIDTH up to 31 (accumulator is carried in 64 bits for saturation).
module gru_hidden_update_alu
   import gru_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAC_BITS  = 8
) (
   input  logic signed [DATA_WIDTH-1:0] n_i,
   input  logic signed [DATA_WIDTH-1:0] z_i,
   input  logic signed [DATA_WIDTH-1:0] h_prev_i,
   output logic signed [DATA_WIDTH-1:0] h_new_o
);
   localparam int unsigned DiffW = DATA_WIDTH + 1;
   localparam int unsigned ProdW = 2 * DATA_WIDTH + 1;
   localparam int unsigned AccW  = 2 * DATA_WIDTH + 2;

   logic signed [DiffW-1:0] diff;
   logic signed [ProdW-1:0] prod;
   logic signed [ProdW-1:0] prod_sh;
   logic signed [AccW-1:0]  acc;

   // Widen every operand explicitly so no intermediate can overflow.
   always_comb begin
      diff    = $signed({h_prev_i[DATA_WIDTH-1], h_prev_i}) - $signed({n_i[DATA_WIDTH-1], n_i});
      prod    = $signed({{(DATA_WIDTH+1){z_i[DATA_WIDTH-1]}}, z_i})
              * $signed({{DATA_WIDTH{diff[DiffW-1]}}, diff});
      prod_sh = prod >>> FRAC_BITS;
      acc     = $signed({{(AccW-DATA_WIDTH){n_i[DATA_WIDTH-1]}}, n_i})
              + $signed({prod_sh[ProdW-1], prod_sh});
      h_new_o = DATA_WIDTH'(sat_to_width($signed({{(64-AccW){acc[AccW-1]}}, acc}), DATA_WIDTH));
   end
endmodule

// File: rtl/gru_gate_sequencer.sv
// Per-row GRU gate sequencer: requests n_t from a shared element for each hidden row,
// blends it with z_t/h_prev into h_t and pulses done after the last row.
// Optional WAIT watchdog enabled by defining GRU_SEQ_TIMEOUT_EN.
module gru_gate_sequencer
   import gru_pkg::*;
#(
   parameter int unsigned H          = 256,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAC_BITS  = 8,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   output logic                             busy,
   output logic                             done,
   output logic                             error,
   output logic [H-1:0][DATA_WIDTH-1:0]     h_t,
   gru_gate_sequencer_if.master             elem_if
);
   localparam int unsigned   RowW    = row_w(H);
   localparam logic [RowW-1:0] LastRow = RowW'(H - 1);

   if (H < 1 || TIMEOUT < 1) begin : g_bad_params
      $error("gru_gate_sequencer: H and TIMEOUT must both be at least 1");
   end

   seq_state_t                   state_q;
   logic [RowW-1:0]              row_q;
   logic signed [DATA_WIDTH-1:0] n_q;
   logic signed [DATA_WIDTH-1:0] h_new;
   logic [H-1:0][DATA_WIDTH-1:0] h_t_q;
   logic                         busy_q;
   logic                         done_q;
   logic                         evi_q;

`ifdef GRU_SEQ_TIMEOUT_EN
   localparam int unsigned     WdW    = row_w(TIMEOUT);
   localparam logic [WdW-1:0]  WdLast = WdW'(TIMEOUT - 1);
   logic [WdW-1:0]             wd_q;
   logic                       error_q;
   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   gru_hidden_update_alu #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
   ) u_alu (
      .n_i      (n_q),
      .z_i      (elem_if.z_t_n),
      .h_prev_i (elem_if.h_prev_n),
      .h_new_o  (h_new)
   );

   assign elem_if.row_idx       = row_q;
   assign elem_if.elem_valid_in = evi_q;
   assign busy                  = busy_q;
   assign done                  = done_q;
   assign h_t                   = h_t_q;

   // FSM with registered outputs; pulses default low and are set on state entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         row_q   <= '0;
         n_q     <= '0;
         h_t_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         evi_q   <= 1'b0;
`ifdef GRU_SEQ_TIMEOUT_EN
         wd_q    <= '0;
         error_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         evi_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StIssue;
                  row_q   <= '0;
                  evi_q   <= 1'b1;
                  busy_q  <= 1'b1;
`ifdef GRU_SEQ_TIMEOUT_EN
                  error_q <= 1'b0;
`endif
               end
            end
            StIssue: begin
               // A response in this cycle is too early and is dropped.
               state_q <= StWait;
`ifdef GRU_SEQ_TIMEOUT_EN
               wd_q    <= '0;
`endif
            end
            StWait: begin
               if (elem_if.elem_valid_out) begin
                  n_q     <= elem_if.elem_result;
                  state_q <= StUpdate;
`ifdef GRU_SEQ_TIMEOUT_EN
               end else if (wd_q == WdLast) begin
                  error_q <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  wd_q    <= wd_q + 1'b1;
`endif
               end
            end
            StUpdate: begin
               h_t_q[row_q] <= h_new;
               if (row_q == LastRow) begin
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  row_q   <= row_q + 1'b1;
                  evi_q   <= 1'b1;
                  state_q <= StIssue;
               end
            end
            StDone: begin
               row_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_gru_gate_sequencer.sv
// Scoreboard bench for gru_gate_sequencer (H=4, Q8.8). Stimulus pushes expected
// row requests and done vectors; a negedge monitor pops and compares them.
module tb_gru_gate_sequencer;
   localparam int unsigned H  = 4;
   localparam int unsigned DW = 16;
   localparam int unsigned FB = 8;
   localparam int unsigned TO = 8;

   typedef struct {
      logic [H-1:0][DW-1:0] h;
      logic                 err;
      int                   lat;   // start..done cycles inclusive; 0 = unchecked
   } done_exp_t;

   logic                 clk   = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic                 busy;
   logic                 done;
   logic                 error;
   logic [H-1:0][DW-1:0] h_t;

   logic [DW-1:0] res_tab [H];
   logic [DW-1:0] z_tab   [H];
   logic [DW-1:0] hp_tab  [H];

   int  lat        = 5;
   bit  stray_en   = 1'b0;
   int  silent_row = -1;
   int  epoch      = 0;

   int        exp_rows [$];
   done_exp_t exp_done [$];
   int        cyc        = 0;
   int        start_cyc  = 0;
   int        done_seen  = 0;
   int        n_checks   = 0;
   int        n_fail     = 0;

   gru_gate_sequencer_if #(.H(H), .DATA_WIDTH(DW)) bus ();

   gru_gate_sequencer #(
      .H          (H),
      .DATA_WIDTH (DW),
      .FRAC_BITS  (FB),
      .TIMEOUT    (TO)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .error   (error),
      .h_t     (h_t),
      .elem_if (bus.master)
   );

   always #5 clk = ~clk;

   assign bus.z_t_n    = z_tab[bus.row_idx];
   assign bus.h_prev_n = hp_tab[bus.row_idx];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Gate element model: optional stray pulse in ISSUE, real result lat cycles later.
   initial begin : element_model
      int r;
      int my_epoch;
      bus.elem_valid_out = 1'b0;
      bus.elem_result    = '0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.elem_valid_in) begin
            r        = int'(bus.row_idx);
            my_epoch = epoch;
            if (stray_en) begin
               bus.elem_valid_out = 1'b1;
               bus.elem_result    = 16'h7777;
            end
            for (int k = 0; k < lat; k++) begin
               @(negedge clk);
               bus.elem_valid_out = 1'b0;
            end
            if (r != silent_row && my_epoch == epoch && rst_n) begin
               bus.elem_valid_out = 1'b1;
               bus.elem_result    = res_tab[r];
            end
         end else begin
            bus.elem_valid_out = 1'b0;
         end
      end
   end

   // Monitor: checks every request pulse and every done pulse against the queues.
   initial begin : monitor
      bit        done_prev;
      bit        evi_prev;
      done_exp_t e;
      done_prev = 1'b0;
      evi_prev  = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            done_prev = 1'b0;
            evi_prev  = 1'b0;
         end else begin
            if (start && !busy) start_cyc = cyc;
            if (bus.elem_valid_in) begin
               check("elem_valid_in_width", longint'(evi_prev), 0);
               if (exp_rows.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_request: got request at row %0d, required none",
                           bus.row_idx);
               end else begin
                  check("row_idx", longint'(bus.row_idx), longint'(exp_rows.pop_front()));
               end
            end
            if (done) begin
               done_seen++;
               check("done_width", longint'(done_prev), 0);
               if (exp_done.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_done: got done pulse, required none");
               end else begin
                  e = exp_done.pop_front();
                  for (int i = 0; i < H; i++) begin
                     check($sformatf("h_t[%0d]", i), longint'(h_t[i]), longint'(e.h[i]));
                  end
                  check("error_at_done", longint'(error), longint'(e.err));
                  if (e.lat > 0) check("done_latency", longint'(cyc - start_cyc + 1), e.lat);
               end
            end
            done_prev = done;
            evi_prev  = bus.elem_valid_in;
         end
      end
   end

   task automatic set_row(input int r, input logic [DW-1:0] res, input logic [DW-1:0] z,
                          input logic [DW-1:0] hp);
      res_tab[r] = res;
      z_tab[r]   = z;
      hp_tab[r]  = hp;
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_sweep(input done_exp_t e, input int nrows, input bit expect_done);
      for (int r = 0; r < nrows; r++) exp_rows.push_back(r);
      if (expect_done) exp_done.push_back(e);
      pulse_start();
   endtask

   task automatic wait_done(input int budget);
      int base;
      base = done_seen;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done_seen > base) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done within %0d cycles, required a done pulse", budget);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, longint'(busy), 0);
      check({tag, "_done"}, longint'(done), 0);
      check({tag, "_elem_valid_in"}, longint'(bus.elem_valid_in), 0);
      check({tag, "_error"}, longint'(error), 0);
      check({tag, "_row_idx"}, longint'(bus.row_idx), 0);
      for (int i = 0; i < H; i++) check($sformatf("%s_h_t[%0d]", tag, i), longint'(h_t[i]), 0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout: got no end of test, required completion");
      $fatal(1, "bench timed out");
   end

   initial begin : stimulus
      done_exp_t e;
      bit        found;
      for (int r = 0; r < H; r++) set_row(r, '0, '0, '0);

      // Reset state.
      #22;
      check_all_zero("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Directed vectors: plain blend, positive/negative saturation, z = 1.0.
      lat = 3;
      set_row(0, 16'h0080, 16'h0040, 16'h0100);
      set_row(1, 16'h7F00, 16'h7FFF, 16'h7FFF);
      set_row(2, 16'h8100, 16'h7FFF, 16'h8000);
      set_row(3, 16'h0555, 16'h0100, 16'h1234);
      e.h[0] = 16'h00A0; e.h[1] = 16'h7FFF; e.h[2] = 16'h8000; e.h[3] = 16'h1234;
      e.err = 1'b0; e.lat = 4 * (2 + 3) + 2;
      run_sweep(e, H, 1'b1);
      wait_done(200);
      repeat (3) @(posedge clk);

      // Full sweep, 5-cycle element, z = 0, stray responses in ISSUE, extra start mid-sweep.
      lat = 5;
      stray_en = 1'b1;
      set_row(0, 16'h0010, 16'h0000, 16'h5A5A);
      set_row(1, 16'h0020, 16'h0000, 16'hA5A5);
      set_row(2, 16'h0030, 16'h0000, 16'h1111);
      set_row(3, 16'h0040, 16'h0000, 16'h7000);
      e.h[0] = 16'h0010; e.h[1] = 16'h0020; e.h[2] = 16'h0030; e.h[3] = 16'h0040;
      e.err = 1'b0; e.lat = 4 * (2 + 5) + 2;
      run_sweep(e, H, 1'b1);
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(200);
      stray_en = 1'b0;
      repeat (8) @(posedge clk);

      // Reset during WAIT of row 2, then a fresh sweep from row 0.
      set_row(0, 16'h0100, 16'h0000, 16'h0000);
      set_row(1, 16'h0200, 16'h0000, 16'h0000);
      set_row(2, 16'h0300, 16'h0000, 16'h0000);
      set_row(3, 16'h0400, 16'h0000, 16'h0000);
      run_sweep(e, 3, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         if (bus.elem_valid_in && bus.row_idx == 2'd2) found = 1'b1;
      end
      check("reached_row2", longint'(found), 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      epoch++;
      #1 check_all_zero("midreset");
      check("rows_left_at_reset", longint'(exp_rows.size()), 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      e.h[0] = 16'h0100; e.h[1] = 16'h0200; e.h[2] = 16'h0300; e.h[3] = 16'h0400;
      e.err = 1'b0; e.lat = 4 * (2 + 5) + 2;
      run_sweep(e, H, 1'b1);
      wait_done(200);
      repeat (8) @(posedge clk);

`ifdef GRU_SEQ_TIMEOUT_EN
      // Row 1 never answers: abort after TO WAIT cycles, rows 1..3 keep old values.
      silent_row = 1;
      set_row(0, 16'h0AAA, 16'h0000, 16'h0000);
      e.h[0] = 16'h0AAA; e.h[1] = 16'h0200; e.h[2] = 16'h0300; e.h[3] = 16'h0400;
      e.err = 1'b1; e.lat = 1 + (2 + 5) + (1 + TO) + 1;
      run_sweep(e, 2, 1'b1);
      wait_done(200);
      repeat (10) @(posedge clk);
      check("error_sticky", longint'(error), 1);
      silent_row = -1;
      set_row(0, 16'h0010, 16'h0000, 16'h0000);
      set_row(1, 16'h0020, 16'h0000, 16'h0000);
      set_row(2, 16'h0030, 16'h0000, 16'h0000);
      set_row(3, 16'h0040, 16'h0000, 16'h0000);
      e.h[0] = 16'h0010; e.h[1] = 16'h0020; e.h[2] = 16'h0030; e.h[3] = 16'h0040;
      e.err = 1'b0; e.lat = 4 * (2 + 5) + 2;
      run_sweep(e, H, 1'b1);
      @(negedge clk);
      check("error_cleared_on_start", longint'(error), 0);
      wait_done(200);
      repeat (4) @(posedge clk);
`endif

      check("rows_left", longint'(exp_rows.size()), 0);
      check("done_left", longint'(exp_done.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/gru_gate_sequencer.md
Name: gru_gate_sequencer

Overview:
- Initiator/collector for per-row GRU gate element engines: issues one `elem_valid_in` request per hidden row, waits for `elem_valid_out`, and captures `elem_result` (n_t for that row).
- Blends the result with z_t and h_prev into the new hidden state: h_t[r] = n + z·(h_prev − n).
- Assembles the full h_t vector and signals `done`.
- Sits between the layer controller (`start`/`done`) and a single time-multiplexed gate element.

Parameters:
- H, 256, number of hidden rows sequenced per step.
- DATA_WIDTH, 16, signed fixed-point word width.
- FRAC_BITS, 8, fractional bits of every word.
- TIMEOUT, 1024, max cycles in WAIT before abort (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin one time step; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last row is written.
- row_idx  out  $clog2(H)  row currently requested; drives weight/bias/z/h_prev muxing.
- elem_valid_in  out  1  one-cycle request pulse to the gate element.
- elem_valid_out  in  1  element result-valid pulse.
- elem_result  in  DATA_WIDTH signed  element output (n_t for row_idx).
- z_t_n  in  DATA_WIDTH signed  update-gate value for row_idx.
- h_prev_n  in  DATA_WIDTH signed  previous hidden value for row_idx.
- h_t  out  DATA_WIDTH signed x H  assembled new hidden state, registered.
- error  out  1  sticky timeout flag (tied 0 without the optional feature).

Behaviour:
- Reset values: state IDLE; row_idx 0; busy, done, elem_valid_in, error 0; every h_t entry 0. Reset mid-operation aborts immediately, with no partial-result retention.
- IDLE: on start, go to ISSUE with row_idx = 0. Clear error on start.
- ISSUE: elem_valid_in = 1 for exactly this cycle; row_idx stays stable; go to WAIT.
- WAIT: hold until elem_valid_out = 1. In that cycle, register elem_result into n_reg and go to UPDATE.
- UPDATE:
  - diff = h_prev_n − n_reg, computed at DATA_WIDTH+1 bits.
  - prod = z_t_n·diff, computed at 2·DATA_WIDTH+1 bits.
  - acc = n_reg + (prod >>> FRAC_BITS), arithmetic shift (truncation toward −inf).
  - Saturate acc to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] and write it to h_t[row_idx].
  - If row_idx == H−1, go to DONE; else increment row_idx and go to ISSUE.
- DONE: done = 1 for one cycle, row_idx returns to 0, go to IDLE. h_t holds until the next write.
- Per-row cost is 2 cycles plus element latency.
- UPDATE guarantees at least 2 cycles between an observed elem_valid_out and the next elem_valid_in, so the element can return to idle.
- start while busy is ignored.
- elem_valid_out outside WAIT is ignored; no capture and no state change.
- elem_valid_out in the same cycle as ISSUE is ignored; the response must arrive in WAIT.
- z_t_n and h_prev_n are sampled combinationally in UPDATE and must be valid for row_idx by then.
- H = 1: ISSUE → WAIT → UPDATE → DONE, with no increment.

Optional Feature:
- Macro GRU_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT without elem_valid_out: set error (sticky until next start), skip UPDATE, go to DONE, pulse done.
  - h_t entries for rows not yet written keep their previous values.
- Undefined: no counter; WAIT waits indefinitely; error tied 0.

Decomposition:
- Shared package gru_pkg holds:
  - seq_state_t enum {IDLE, ISSUE, WAIT, UPDATE, DONE};
  - ROW_W = $clog2(H) helper;
  - function sat_to_width (signed saturate of a wide value to DATA_WIDTH).
- One natural sub-module: gru_hidden_update_alu, combinational; inputs n, z, h_prev; output saturated h_new. It performs the diff/multiply/shift/saturate.
- The sequencer keeps the FSM, row counter, watchdog and h_t register file.

Test Plan:
- Single row, H=4, FRAC_BITS=8, row 0: elem_result=0x0080, z=0x0040, h_prev=0x0100 → h_t[0]=0x00A0.
- Saturation: elem_result=0x7F00, z=0x7FFF, h_prev=0x7FFF → h_t[r]=0x7FFF. Negative case: elem_result=0x8100, z=0x7FFF, h_prev=0x8000 → h_t[r]=0x8000.
- Full sweep, H=4, element model with 5-cycle latency returning 0x0010·(r+1), z=0, h_prev arbitrary:
  - h_t = {0x0010, 0x0020, 0x0030, 0x0040};
  - exactly 4 elem_valid_in pulses, row_idx 0→3;
  - done is one pulse, 4·(2+5)+2 cycles after start.
- Protocol abuse:
  - start asserted again mid-sweep → ignored, row sequence unchanged;
  - stray elem_valid_out while in ISSUE → ignored, WAIT still entered;
  - z=0x0100 → h_t[r] = h_prev.
- Reset mid-operation: rst_n low during WAIT of row 2 → all outputs 0 asynchronously, state IDLE; a fresh start restarts at row 0.
- GRU_SEQ_TIMEOUT_EN, TIMEOUT=8, element never responds on row 1 → after 8 WAIT cycles error=1 and done pulses; h_t[0] is updated, h_t[1..3] unchanged; the next start clears error.
